// File: rtl/cpu_run_controller.sv
// Run controller for a pipelined CPU: streams a program into instruction memory, runs it
// under a cycle budget, then captures one register. Halt detection is enabled by CPU_RUN_HALT_DETECT_EN.
module cpu_run_controller #(
  parameter int DATA_W      = 32,
  parameter int IADDR_W     = 8,
  parameter int RADDR_W     = 6,
  parameter int CYC_W       = 16,
  parameter int HALT_REPEAT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ld_valid,
  input  logic [DATA_W-1:0]  ld_data,
  input  logic               ld_last,
  output logic               ld_ready,
  input  logic               start,
  input  logic [CYC_W-1:0]   cycle_limit,
  input  logic [RADDR_W-1:0] result_reg,
  output logic               imem_we,
  output logic [IADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0]  imem_wdata,
  output logic               cpu_reset,
  input  logic [DATA_W-1:0]  cpu_pc,
  output logic [RADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0]  rf_rdata,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic               halted,
  output logic [DATA_W-1:0]  result,
  output logic [CYC_W-1:0]   cycles
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, READ, DONE} state_t;

  state_t             state;
  logic [IADDR_W-1:0] ptr;
  logic [CYC_W-1:0]   limit_q;
  logic [RADDR_W-1:0] rsel_q;
  logic               accept;
  logic               load_end;
  logic               budget_hit;
  logic               halt_hit;

  // Reset gates the handshake so no memory write can slip through while reset is held.
  assign ld_ready   = !reset && (state inside {IDLE, LOAD, DONE});
  assign accept     = ld_valid && ld_ready;
  assign load_end   = ld_last || (&ptr);
  assign imem_we    = accept;
  assign imem_addr  = ptr;
  assign imem_wdata = ld_data;

  assign cpu_reset = !(state inside {RUN, READ});
  assign busy      = state inside {LOAD, RUN, READ};
  assign done      = (state == DONE);
  assign rf_raddr  = (state == READ) ? rsel_q : '0;

  // Compared against the pre-increment count, so a limit of 0 wraps to all-ones and
  // fires after 2^CYC_W cycles, exactly where the saturating counter tops out.
  assign budget_hit = (cycles == limit_q - CYC_W'(1));

`ifdef CPU_RUN_HALT_DETECT_EN
  localparam int HCNT_W = $clog2(HALT_REPEAT + 1);

  logic [DATA_W-1:0] prev_pc;
  logic              prev_valid;
  logic [HCNT_W-1:0] halt_cnt;

  assign halt_hit = prev_valid && (cpu_pc == prev_pc) &&
                    (halt_cnt == HCNT_W'(HALT_REPEAT - 1));

  // Held clear outside RUN, so every run starts with an empty history.
  always_ff @(posedge clk) begin
    if (reset || state != RUN) begin
      prev_pc    <= '0;
      prev_valid <= 1'b0;
      halt_cnt   <= '0;
    end else begin
      prev_pc    <= cpu_pc;
      prev_valid <= 1'b1;
      if (prev_valid && cpu_pc == prev_pc) halt_cnt <= halt_cnt + HCNT_W'(1);
      else                                 halt_cnt <= '0;
    end
  end
`else
  logic unused_halt_inputs;
  assign unused_halt_inputs = (^cpu_pc) ^ HALT_REPEAT[0];
  assign halt_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      limit_q <= '0;
      rsel_q  <= '0;
      timeout <= 1'b0;
      halted  <= 1'b0;
      result  <= '0;
      cycles  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads pre-edge values.
      if (accept) ptr <= load_end ? '0 : ptr + IADDR_W'(1);

      case (state)
        IDLE, DONE: begin
          if (accept) begin
            state   <= load_end ? IDLE : LOAD;
            timeout <= 1'b0;
            halted  <= 1'b0;
          end else if (start) begin
            state   <= RUN;
            limit_q <= cycle_limit;
            rsel_q  <= result_reg;
            cycles  <= '0;
            timeout <= 1'b0;
            halted  <= 1'b0;
          end
        end
        LOAD: begin
          if (accept && load_end) state <= IDLE;
        end
        RUN: begin
          if (cycles != '1) cycles <= cycles + CYC_W'(1);
          if (halt_hit) begin
            halted <= 1'b1;
            state  <= READ;
          end else if (budget_hit) begin
            timeout <= 1'b1;
            state   <= READ;
          end
        end
        READ: begin
          result <= rf_rdata;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed, table-driven bench for cpu_run_controller: program loading, timed runs,
// halt detection (when CPU_RUN_HALT_DETECT_EN is defined), and reset mid-operation.
module tb_cpu_run_controller;

  localparam int DATA_W  = 32;
  localparam int IADDR_W = 8;
  localparam int RADDR_W = 6;
  localparam int CYC_W   = 16;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               ld_valid = 1'b0;
  logic [DATA_W-1:0]  ld_data = '0;
  logic               ld_last = 1'b0;
  logic               ld_ready;
  logic               start = 1'b0;
  logic [CYC_W-1:0]   cycle_limit = '0;
  logic [RADDR_W-1:0] result_reg = '0;
  logic               imem_we;
  logic [IADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0]  imem_wdata;
  logic               cpu_reset;
  logic [DATA_W-1:0]  cpu_pc;
  logic [RADDR_W-1:0] rf_raddr;
  logic [DATA_W-1:0]  rf_rdata;
  logic               busy, done, timeout, halted;
  logic [DATA_W-1:0]  result;
  logic [CYC_W-1:0]   cycles;

  int n_checks = 0;
  int n_err    = 0;

  // CPU stand-in: PC advances every cycle out of reset, or freezes at 0x11 from run cycle 5.
  int   run_cyc = 0;
  logic freeze  = 1'b0;
  logic [DATA_W-1:0] regs [64];

  always #5 clk = ~clk;

  always @(posedge clk) run_cyc <= cpu_reset ? 0 : run_cyc + 1;
  assign cpu_pc   = (freeze && run_cyc >= 4) ? 32'h11 : 32'(run_cyc + 1);
  assign rf_rdata = regs[rf_raddr];

  cpu_run_controller dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .start(start), .cycle_limit(cycle_limit), .result_reg(result_reg),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .cpu_pc(cpu_pc),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .busy(busy), .done(done), .timeout(timeout), .halted(halted),
    .result(result), .cycles(cycles)
  );

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic        last;
    logic        exp_we;
    int          exp_addr;
    logic        exp_busy;
  } load_vec_t;

  typedef struct {
    int   limit;
    int   rreg;
    logic freeze;
    int   exp_cycles;
    logic exp_to;
    logic exp_halt;
  } run_vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One accepted beat driven at a falling edge; returns at the next falling edge.
  task automatic beat(input logic [31:0] data, input logic last, input int exp_addr,
                      input string tag);
    ld_valid = 1'b1;
    ld_data  = data;
    ld_last  = last;
    #1;
    check({tag, " we"}, imem_we, 1);
    check({tag, " addr"}, imem_addr, exp_addr);
    check({tag, " wdata"}, imem_wdata, data);
    @(negedge clk);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic do_run(input run_vec_t v, input int idx);
    logic [31:0] exp_res;
    string       t;
    exp_res     = regs[v.rreg];
    t           = $sformatf("run%0d", idx);
    freeze      = v.freeze;
    cycle_limit = CYC_W'(v.limit);
    result_reg  = RADDR_W'(v.rreg);
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({t, " busy"}, busy, 1);
    check({t, " cpu_reset"}, cpu_reset, 0);
    check({t, " ld_ready"}, ld_ready, 0);
    check({t, " cycles0"}, cycles, 0);
    repeat (v.exp_cycles - 1) @(negedge clk);
    check({t, " pre cycles"}, cycles, v.exp_cycles - 1);
    check({t, " pre timeout"}, timeout, 0);
    check({t, " pre halted"}, halted, 0);
    check({t, " pre raddr"}, rf_raddr, 0);
    @(negedge clk);
    check({t, " read busy"}, busy, 1);
    check({t, " read done"}, done, 0);
    check({t, " read raddr"}, rf_raddr, v.rreg);
    check({t, " read cycles"}, cycles, v.exp_cycles);
    check({t, " read timeout"}, timeout, v.exp_to);
    check({t, " read halted"}, halted, v.exp_halt);
    @(negedge clk);
    check({t, " done"}, done, 1);
    check({t, " done busy"}, busy, 0);
    check({t, " done cpu_reset"}, cpu_reset, 1);
    check({t, " result"}, result, exp_res);
    repeat (3) @(negedge clk);
    check({t, " hold done"}, done, 1);
    check({t, " hold result"}, result, exp_res);
    check({t, " hold cycles"}, cycles, v.exp_cycles);
    check({t, " hold timeout"}, timeout, v.exp_to);
    check({t, " hold halted"}, halted, v.exp_halt);
  endtask

  initial begin
    load_vec_t lv [4];
    run_vec_t  rv [5];

    lv[0] = '{1'b1, 32'hE1, 1'b0, 1'b1, 0, 1'b1};
    lv[1] = '{1'b1, 32'hF2, 1'b0, 1'b1, 1, 1'b1};
    lv[2] = '{1'b1, 32'hF3, 1'b1, 1'b1, 2, 1'b0};
    lv[3] = '{1'b0, 32'h00, 1'b0, 1'b0, 0, 1'b0};

    rv[0] = '{10, 10, 1'b0, 10, 1'b1, 1'b0};
    rv[1] = '{1,  3,  1'b0, 1,  1'b1, 1'b0};
    rv[2] = '{3,  63, 1'b0, 3,  1'b1, 1'b0};
`ifdef CPU_RUN_HALT_DETECT_EN
    rv[3] = '{100, 5, 1'b1, 9, 1'b0, 1'b1};
    rv[4] = '{9,   6, 1'b1, 9, 1'b0, 1'b1};
`else
    rv[3] = '{20,  5, 1'b1, 20, 1'b1, 1'b0};
    rv[4] = '{9,   6, 1'b1, 9,  1'b1, 1'b0};
`endif

    for (int i = 0; i < 64; i++) regs[i] = (32'(i) * 32'h0101_0101) ^ 32'h5A;
    regs[10] = 32'd7;

    repeat (3) @(negedge clk);
    check("rst cpu_reset", cpu_reset, 1);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst timeout", timeout, 0);
    check("rst halted", halted, 0);
    check("rst result", result, 0);
    check("rst cycles", cycles, 0);
    check("rst raddr", rf_raddr, 0);
    check("rst we", imem_we, 0);
    reset = 1'b0;
    #1;
    check("idle ld_ready", ld_ready, 1);

    // Three-beat program load.
    for (int i = 0; i < 4; i++) begin
      ld_valid = lv[i].valid;
      ld_data  = lv[i].data;
      ld_last  = lv[i].last;
      #1;
      check($sformatf("load%0d we", i), imem_we, lv[i].exp_we);
      if (lv[i].exp_we) begin
        check($sformatf("load%0d addr", i), imem_addr, lv[i].exp_addr);
        check($sformatf("load%0d wdata", i), imem_wdata, lv[i].data);
      end
      @(negedge clk);
      check($sformatf("load%0d busy", i), busy, lv[i].exp_busy);
    end
    ld_valid = 1'b0;

    // Start coinciding with a beat: the load wins.
    start = 1'b1;
    beat(32'hAB, 1'b0, 0, "coincide");
    start = 1'b0;
    check("coincide busy", busy, 1);
    check("coincide cpu_reset", cpu_reset, 1);
    check("coincide done", done, 0);
    beat(32'hAC, 1'b1, 1, "coincide end");
    check("coincide idle", busy, 0);

    for (int i = 0; i < 5; i++) do_run(rv[i], i);

    // Loading from DONE clears the previous run's status.
    beat(32'h55, 1'b0, 0, "reload");
    check("reload busy", busy, 1);
    check("reload done", done, 0);
    check("reload timeout", timeout, 0);
    check("reload halted", halted, 0);
    beat(32'h66, 1'b1, 1, "reload end");

    // Full-depth load without ld_last terminates itself and restarts at 0.
    for (int i = 0; i < 256; i++) beat(32'(i * 3 + 1), 1'b0, i, $sformatf("bulk%0d", i));
    check("bulk idle", busy, 0);
    beat(32'h77, 1'b1, 0, "bulk wrap");
    check("bulk wrap idle", busy, 0);

    // Reset in the middle of a run.
    do_run(rv[0], 5);
    freeze      = 1'b0;
    cycle_limit = CYC_W'(50);
    result_reg  = RADDR_W'(2);
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("midrun cycles", cycles, 5);
    reset = 1'b1;
    @(negedge clk);
    check("midrun rst cpu_reset", cpu_reset, 1);
    check("midrun rst busy", busy, 0);
    check("midrun rst done", done, 0);
    check("midrun rst cycles", cycles, 0);
    check("midrun rst result", result, 0);
    check("midrun rst timeout", timeout, 0);
    check("midrun rst raddr", rf_raddr, 0);
    reset = 1'b0;

    // Reset in the middle of a load rewinds the pointer.
    beat(32'h01, 1'b0, 0, "midload0");
    beat(32'h02, 1'b0, 1, "midload1");
    reset = 1'b1;
    @(negedge clk);
    check("midload rst busy", busy, 0);
    reset = 1'b0;
    beat(32'h03, 1'b1, 0, "midload after");
    check("midload idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
